sgmii_port_deinterleaver: RTL

Parametrised RX-side splitter for port-interleaved SGMII links such as QSGMII (4 ports) and 2- or 8-port variants, all at 125 MHz. It takes one decoded transceiver word per clock carrying one 8b/10b symbol per port. It locates port 0 by the K28.1 marker using a lock/unlock hysteresis state machine, rotates lanes so output lane N is always port N, and restores K28.5 on port 0. Outputs feed per-port GigBaseXPCS RX instances; TX disparity tracking and muxing stay in a separate block.

---
 rtl/sgmii_port_deinterleaver.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sgmii_port_deinterleaver.sv
// rtl/sgmii_port_deinterleaver.sv - K28.1-locked port de-interleaver for QSGMII-style RX links
// Optional per-port error counters enabled by SGMII_DEINTERLEAVE_ERRCNT_EN.
module sgmii_port_deinterleaver #(
    parameter int  NUM_PORTS    = 4,
    parameter int  LOCK_COUNT   = 4,
    parameter int  UNLOCK_COUNT = 8,
    localparam int LW           = $clog2(NUM_PORTS)
) (
    input  logic                   rx_clk,
    input  logic                   rx_rst,
    input  logic                   rx_data_valid,
    input  logic [NUM_PORTS-1:0]   rx_data_is_ctl,
    input  logic [8*NUM_PORTS-1:0] rx_data,
    input  logic [NUM_PORTS-1:0]   rx_disparity_err,
    input  logic [NUM_PORTS-1:0]   rx_symbol_err,
    output logic                   sgmii_rx_data_valid,
    output logic [NUM_PORTS-1:0]   sgmii_rx_data_is_ctl,
    output logic [8*NUM_PORTS-1:0] sgmii_rx_data,
    output logic [NUM_PORTS-1:0]   sgmii_rx_disparity_err,
    output logic [NUM_PORTS-1:0]   sgmii_rx_symbol_err,
    output logic                   locked,
    output logic [LW-1:0]          lock_lane
`ifdef SGMII_DEINTERLEAVE_ERRCNT_EN
    ,
    input  logic                    err_count_clear,
    output logic [16*NUM_PORTS-1:0] port_err_count
`endif
);

    typedef enum logic [1:0] {
        ST_UNLOCKED,
        ST_LOCKING,
        ST_LOCKED
    } state_t;

    state_t state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    miss_q, miss_d;
    logic [LW-1:0] lane_q, lane_d;

    logic [NUM_PORTS-1:0] marker;
    logic [4:0]           n_marker;
    logic [LW-1:0]        marker_lane;
    logic [3:0]           marker_lane4;
    logic                 single_mk;
    logic                 multi_mk;

    logic                   valid_q, valid_d;
    logic [NUM_PORTS-1:0]   ctl_q, ctl_d;
    logic [8*NUM_PORTS-1:0] data_q, data_d;
    logic [NUM_PORTS-1:0]   derr_q, derr_d;
    logic [NUM_PORTS-1:0]   serr_q, serr_d;
    logic [LW-1:0]          src [NUM_PORTS];

    always_comb begin
        marker      = '0;
        n_marker    = '0;
        marker_lane = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            marker[i] = rx_data_is_ctl[i] && (rx_data[8*i +: 8] == 8'h3c);
            if (marker[i]) begin
                n_marker    = n_marker + 5'd1;
                marker_lane = LW'(i);
            end
        end
    end

    assign marker_lane4 = {{(4-LW){1'b0}}, marker_lane};
    assign single_mk    = (n_marker == 5'd1);
    assign multi_mk     = (n_marker > 5'd1);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        miss_d  = miss_q;
        lane_d  = lane_q;
        if (rx_data_valid) begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (single_mk) begin
                        cand_d = marker_lane4;
                        cnt_d  = 4'd1;
                        if (LOCK_COUNT == 1) begin
                            state_d = ST_LOCKED;
                            lane_d  = marker_lane;
                            miss_d  = 4'd0;
                        end else begin
                            state_d = ST_LOCKING;
                        end
                    end
                end
                ST_LOCKING: begin
                    if (multi_mk) begin
                        state_d = ST_UNLOCKED;
                    end else if (single_mk && marker_lane4 == cand_q) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == 4'(LOCK_COUNT)) begin
                            state_d = ST_LOCKED;
                            lane_d  = cand_q[LW-1:0];
                            miss_d  = 4'd0;
                        end
                    end else if (single_mk) begin
                        cand_d = marker_lane4;
                        cnt_d  = 4'd1;
                    end
                end
                ST_LOCKED: begin
                    if (single_mk && marker_lane == lane_q) begin
                        miss_d = 4'd0;
                    end else if (single_mk || multi_mk) begin
                        // lock_lane is deliberately kept on unlock; only reset clears it
                        if (miss_q + 4'd1 == 4'(UNLOCK_COUNT)) begin
                            state_d = ST_UNLOCKED;
                            miss_d  = 4'd0;
                        end else begin
                            miss_d = miss_q + 4'd1;
                        end
                    end
                end
                default: state_d = ST_UNLOCKED;
            endcase
        end
    end

    // Rotation uses the pre-update lane so a new lock applies from the next word.
    always_comb begin
        valid_d = rx_data_valid && (state_q == ST_LOCKED);
        ctl_d   = '0;
        data_d  = '0;
        derr_d  = '0;
        serr_d  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            src[i]           = LW'(i) + lane_q;
            data_d[8*i +: 8] = rx_data[8*int'(src[i]) +: 8];
            ctl_d[i]         = rx_data_is_ctl[src[i]];
            derr_d[i]        = rx_disparity_err[src[i]];
            serr_d[i]        = rx_symbol_err[src[i]];
        end
        if (marker[src[0]]) begin
            data_d[7:0] = 8'hbc;
            ctl_d[0]    = 1'b1;
        end
    end

`ifdef SGMII_DEINTERLEAVE_ERRCNT_EN
    logic [16*NUM_PORTS-1:0] errcnt_q, errcnt_d;

    always_comb begin
        errcnt_d = errcnt_q;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (err_count_clear) begin
                errcnt_d[16*i +: 16] = 16'h0000;
            end else if (valid_d && (derr_d[i] || serr_d[i]) &&
                         errcnt_q[16*i +: 16] != 16'hffff) begin
                errcnt_d[16*i +: 16] = errcnt_q[16*i +: 16] + 16'd1;
            end
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            errcnt_q <= '0;
        end else begin
            errcnt_q <= errcnt_d;
        end
    end

    assign port_err_count = errcnt_q;
`endif

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state_q <= ST_UNLOCKED;
            cand_q  <= '0;
            cnt_q   <= '0;
            miss_q  <= '0;
            lane_q  <= '0;
            valid_q <= 1'b0;
            ctl_q   <= '0;
            data_q  <= '0;
            derr_q  <= '0;
            serr_q  <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            miss_q  <= miss_d;
            lane_q  <= lane_d;
            valid_q <= valid_d;
            ctl_q   <= ctl_d;
            data_q  <= data_d;
            derr_q  <= derr_d;
            serr_q  <= serr_d;
        end
    end

    assign sgmii_rx_data_valid    = valid_q;
    assign sgmii_rx_data_is_ctl   = ctl_q;
    assign sgmii_rx_data          = data_q;
    assign sgmii_rx_disparity_err = derr_q;
    assign sgmii_rx_symbol_err    = serr_q;
    assign locked                 = (state_q == ST_LOCKED);
    assign lock_lane              = lane_q;

endmodule
